apb_uart_tx_sched: RTL and testbench

APB master that brings up the `apb_uart_sv` UART after reset and shares its transmit path among `NUM_REQ` byte-stream requesters. It programs the divisor, line control and FIFO control registers, then arbitrates requesters round-robin. It tracks TX FIFO space with a credit counter, refilled by polling LSR. It sits between on-chip byte producers (debug, console, trace) and the UART's APB slave port.

---
 rtl/apb_uart_tx_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_apb_uart_tx_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_tx_sched.sv
// APB master that initialises the UART and then shares its TX FIFO among
// NUM_REQ byte requesters, round-robin, with LSR-polled credit refill.
module apb_uart_tx_sched #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TX_FIFO_DEPTH  = 16,
  parameter logic [15:0] DIV            = 16'd54,
  parameter logic [7:0]  LCR_CFG        = 8'h03,
  parameter int unsigned POLL_GAP       = 8
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      reinit_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [8*NUM_REQ-1:0]      req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      init_done_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CRED_W = $clog2(TX_FIFO_DEPTH) + 1;
  localparam int unsigned GAP_W  = $clog2(POLL_GAP) + 1;

  localparam logic [3:0] S_INIT_DLAB = 4'd0;
  localparam logic [3:0] S_INIT_DLL  = 4'd1;
  localparam logic [3:0] S_INIT_DLM  = 4'd2;
  localparam logic [3:0] S_INIT_LCR  = 4'd3;
  localparam logic [3:0] S_INIT_FCR  = 4'd4;
  localparam logic [3:0] S_IDLE      = 4'd5;
  localparam logic [3:0] S_WRITE     = 4'd6;
  localparam logic [3:0] S_POLL      = 4'd7;
  localparam logic [3:0] S_GAP       = 4'd8;

  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_SETUP  = 2'd1;
  localparam logic [1:0] PH_ACCESS = 2'd2;

  localparam logic [APB_ADDR_WIDTH-1:0] A_THR = APB_ADDR_WIDTH'(8'h00);
  localparam logic [APB_ADDR_WIDTH-1:0] A_DLM = APB_ADDR_WIDTH'(8'h04);
  localparam logic [APB_ADDR_WIDTH-1:0] A_FCR = APB_ADDR_WIDTH'(8'h08);
  localparam logic [APB_ADDR_WIDTH-1:0] A_LCR = APB_ADDR_WIDTH'(8'h0C);
  localparam logic [APB_ADDR_WIDTH-1:0] A_LSR = APB_ADDR_WIDTH'(8'h14);

  logic [3:0]                state_q, state_d;
  logic [1:0]                phase_q, phase_d;
  logic [CRED_W-1:0]         credits_q, credits_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W-1:0]          winner_q, winner_d;
  logic [7:0]                wbyte_q, wbyte_d;
  logic [GAP_W-1:0]          gap_q, gap_d;
  logic                      pending_q, pending_d;
  logic                      init_done_q, init_done_d;
  logic [NUM_REQ-1:0]        ready_q, ready_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;

  logic [NUM_REQ-1:0] eff_valid;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic [7:0]         win_byte;

  logic unused_apb;
  assign unused_apb = ^{PSLVERR, PRDATA[31:6], PRDATA[4:0]};

  // A requester being acked this cycle still shows its old byte, so skip it.
  always_comb begin
    eff_valid = req_valid_i & ~ready_q;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    win_byte  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % int'(NUM_REQ));
      if (!win_found && eff_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (IDX_W'(i) == win_idx) win_byte = req_data_i[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    credits_d   = credits_q;
    ptr_d       = ptr_q;
    winner_d    = winner_q;
    wbyte_d     = wbyte_q;
    gap_d       = gap_q;
    pending_d   = pending_q | reinit_i;
    init_done_d = init_done_q;
    ready_d     = '0;

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          pending_d   = reinit_i;
          init_done_d = 1'b0;
          state_d     = S_INIT_DLAB;
          phase_d     = PH_SETUP;
        end else if (win_found) begin
          winner_d = win_idx;
          wbyte_d  = win_byte;
          state_d  = (credits_q != '0) ? S_WRITE : S_POLL;
          phase_d  = PH_SETUP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(POLL_GAP - 1)) state_d = S_IDLE;
        else gap_d = gap_q + GAP_W'(1);
      end
      default: begin
        if (phase_q == PH_IDLE) begin
          phase_d = PH_SETUP;
        end else if (phase_q == PH_SETUP) begin
          phase_d = PH_ACCESS;
        end else if (PREADY) begin
          phase_d = PH_IDLE;
          case (state_q)
            S_INIT_DLAB: state_d = S_INIT_DLL;
            S_INIT_DLL:  state_d = S_INIT_DLM;
            S_INIT_DLM:  state_d = S_INIT_LCR;
            S_INIT_LCR:  state_d = S_INIT_FCR;
            S_INIT_FCR: begin
              state_d     = S_IDLE;
              credits_d   = '0;
              init_done_d = 1'b1;
            end
            S_WRITE: begin
              state_d          = S_IDLE;
              ready_d[winner_q] = 1'b1;
              if (credits_q != '0) credits_d = credits_q - CRED_W'(1);
              ptr_d = IDX_W'((int'(winner_q) + 1) % int'(NUM_REQ));
            end
            S_POLL: begin
              if (PRDATA[5]) begin
                credits_d = CRED_W'(TX_FIFO_DEPTH);
                state_d   = S_IDLE;
              end else begin
                gap_d   = '0;
                state_d = S_GAP;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase

    // APB pins follow the next state/phase so they are registered with it.
    psel_d    = 1'b0;
    penable_d = 1'b0;
    pwrite_d  = 1'b0;
    paddr_d   = '0;
    pwdata_d  = '0;
    if (phase_d != PH_IDLE) begin
      psel_d    = 1'b1;
      penable_d = (phase_d == PH_ACCESS);
      pwrite_d  = 1'b1;
      case (state_d)
        S_INIT_DLAB: begin paddr_d = A_LCR; pwdata_d = 32'h0000_0080; end
        S_INIT_DLL:  begin paddr_d = A_THR; pwdata_d = {24'h0, DIV[7:0]}; end
        S_INIT_DLM:  begin paddr_d = A_DLM; pwdata_d = {24'h0, DIV[15:8]}; end
        S_INIT_LCR:  begin paddr_d = A_LCR; pwdata_d = {24'h0, LCR_CFG & 8'h7F}; end
        S_INIT_FCR:  begin paddr_d = A_FCR; pwdata_d = 32'h0000_0006; end
        S_WRITE:     begin paddr_d = A_THR; pwdata_d = {24'h0, wbyte_d}; end
        S_POLL:      begin paddr_d = A_LSR; pwrite_d = 1'b0; end
        default:     ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_INIT_DLAB;
      phase_q     <= PH_IDLE;
      credits_q   <= '0;
      ptr_q       <= '0;
      winner_q    <= '0;
      wbyte_q     <= '0;
      gap_q       <= '0;
      pending_q   <= 1'b0;
      init_done_q <= 1'b0;
      ready_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      credits_q   <= credits_d;
      ptr_q       <= ptr_d;
      winner_q    <= winner_d;
      wbyte_q     <= wbyte_d;
      gap_q       <= gap_d;
      pending_q   <= pending_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign req_ready_o = ready_q;
  assign init_done_o = init_done_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_uart_tx_sched.sv
// Directed bench for apb_uart_tx_sched: init sequence, credits/polling,
// round-robin order, wait states, reinit and asynchronous reset.
module tb_apb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        reinit = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        init_done;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite, psel, penable;
  logic [31:0] prdata = 32'h0;
  logic        pready = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int          ev_kind[$];
  logic [11:0] ev_addr[$];
  logic [31:0] ev_data[$];
  int          ev_cyc[$];
  int          gnt_log[$];
  int          sent[4] = '{default: 0};
  int          limit[4] = '{default: 0};
  int          lsr_reads = 0;
  int          lsr_fail_until = 0;
  int          multi_hot = 0;

  apb_uart_tx_sched #(
    .NUM_REQ(4), .APB_ADDR_WIDTH(12), .TX_FIFO_DEPTH(16),
    .DIV(16'd54), .LCR_CFG(8'h03), .POLL_GAP(8)
  ) dut (
    .CLK(clk), .RSTN(rstn), .reinit_i(reinit),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .init_done_o(init_done),
    .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(1'b0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] byte_of(input int r, input int n);
    return 8'((r << 6) | (n & 63));
  endfunction

  // APB slave model and transfer/grant logger.
  always @(negedge clk) begin
    if (rstn && psel && penable && pready) begin
      if (!pwrite) begin
        prdata = (lsr_reads < lsr_fail_until) ? 32'h0000_0000 : 32'h0000_0060;
        lsr_reads++;
      end
      ev_kind.push_back(pwrite ? 0 : 1);
      ev_addr.push_back(paddr);
      ev_data.push_back(pwrite ? pwdata : prdata);
      ev_cyc.push_back(cyc);
    end
    if (rstn && req_ready != 4'b0) begin
      if ($countones(req_ready) > 1) multi_hot++;
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i]) begin
          gnt_log.push_back(i);
          sent[i]++;
        end
      end
    end
  end

  // Requester i offers byte_of(i, sent[i]) until sent[i] reaches limit[i].
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = rstn && (sent[i] < limit[i]);
      req_data[8*i +: 8] = byte_of(i, sent[i]);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sent(input int r, input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sent[r] >= target) break;
    end
    check($sformatf("sent%0d_reached", r), 32'(sent[r]), 32'(target));
  endtask

  task automatic find_thr_setup(input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (psel && !penable && pwrite && paddr == 12'h000) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic check_init(input string pfx, input int base);
    logic [11:0] ia [5];
    logic [31:0] id [5];
    ia = '{12'h00C, 12'h000, 12'h004, 12'h00C, 12'h008};
    id = '{32'h80, 32'h36, 32'h00, 32'h03, 32'h06};
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s_w%0d_kind", pfx, k), 32'(ev_kind[base+k]), 32'd0);
      check($sformatf("%s_w%0d_addr", pfx, k), 32'(ev_addr[base+k]), 32'(ia[k]));
      check($sformatf("%s_w%0d_data", pfx, k), ev_data[base+k], id[k]);
    end
  endtask

  initial begin
    int c0, m, gm, bad, w, r, n;
    int b[4];

    // Reset values.
    #1 rstn = 1'b0;
    #2;
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_pwrite", 32'(pwrite), 32'd0);
    check("rst_paddr", 32'(paddr), 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);

    // Init sequence and its latency.
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (init_done) break;
    end
    check("init_done_latency", 32'(cyc - c0), 32'd15);
    check("init_event_count", 32'(ev_kind.size()), 32'd5);
    check_init("init", 0);

    // One requester, 20 bytes: poll, 16 writes, poll, 4 writes.
    m = ev_kind.size();
    limit[0] = 20;
    wait_sent(0, 20, 400);
    check("t3_event_count", 32'(ev_kind.size() - m), 32'd22);
    check("t3_first_poll", 32'(ev_kind[m]), 32'd1);
    check("t3_second_poll", 32'(ev_kind[m+17]), 32'd1);
    bad = 0;
    w = 0;
    for (int k = 0; k < 22; k++) begin
      if (k == 0 || k == 17) begin
        if (ev_addr[m+k] != 12'h014) bad++;
      end else begin
        if (ev_kind[m+k] != 0 || ev_addr[m+k] != 12'h000 ||
            ev_data[m+k] != {24'h0, byte_of(0, w)}) bad++;
        w++;
      end
    end
    check("t3_seq_errors", 32'(bad), 32'd0);

    // All four requesters continuously valid; pointer sits at 1 after requester 0.
    m = ev_kind.size();
    gm = gnt_log.size();
    for (int i = 0; i < 4; i++) begin
      b[i] = sent[i];
      limit[i] = sent[i] + 6;
    end
    for (int i = 0; i < 4; i++) wait_sent(i, b[i] + 6, 400);
    check("t4_grant_count", 32'(gnt_log.size() - gm), 32'd24);
    bad = 0;
    for (int k = 0; k < 24; k++) if (gnt_log[gm+k] != (1 + k) % 4) bad++;
    check("t4_grant_order_errors", 32'(bad), 32'd0);
    bad = 0;
    w = 0;
    for (int k = m; k < ev_kind.size(); k++) begin
      if (ev_kind[k] == 0) begin
        r = (1 + w) % 4;
        if (ev_data[k] != {24'h0, byte_of(r, b[r] + w / 4)}) bad++;
        w++;
      end
    end
    check("t4_write_count", 32'(w), 32'd24);
    check("t4_write_data_errors", 32'(bad), 32'd0);

    // Drain the 4 remaining credits without polling.
    m = ev_kind.size();
    limit[1] = sent[1] + 4;
    wait_sent(1, limit[1], 200);
    check("t5_drain_events", 32'(ev_kind.size() - m), 32'd4);

    // LSR not-empty three times, then empty.
    m = ev_kind.size();
    lsr_fail_until = lsr_reads + 3;
    n = sent[1];
    limit[1] = n + 2;
    wait_sent(1, n + 2, 400);
    check("t5_event_count", 32'(ev_kind.size() - m), 32'd6);
    for (int k = 0; k < 4; k++)
      check($sformatf("t5_poll%0d_kind", k), 32'(ev_kind[m+k]), 32'd1);
    for (int k = 1; k < 4; k++)
      check($sformatf("t5_poll_gap%0d", k), 32'(ev_cyc[m+k] - ev_cyc[m+k-1]), 32'd11);
    check("t5_w0_data", ev_data[m+4], {24'h0, byte_of(1, n)});
    check("t5_w1_data", ev_data[m+5], {24'h0, byte_of(1, n + 1)});

    // Four wait states on a THR write.
    m = ev_kind.size();
    n = sent[2];
    limit[2] = n + 1;
    find_thr_setup("t6_setup_seen");
    @(posedge clk);
    #1 pready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t6_wait%0d_penable", k), 32'(penable), 32'd1);
      check($sformatf("t6_wait%0d_paddr", k), 32'(paddr), 32'h000);
      check($sformatf("t6_wait%0d_pwdata", k), pwdata, {24'h0, byte_of(2, n)});
      check($sformatf("t6_wait%0d_ready", k), 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    pready = 1'b1;
    @(negedge clk);
    check("t6_ready_during_last_access", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("t6_ready_pulse", 32'(req_ready), 32'b0100);
    repeat (4) @(negedge clk);
    check("t6_write_count", 32'(ev_kind.size() - m), 32'd1);
    check("t6_write_data", ev_data[m], {24'h0, byte_of(2, n)});

    // Reinit during a THR access.
    m = ev_kind.size();
    n = sent[3];
    limit[3] = n + 2;
    find_thr_setup("t7_setup_seen");
    @(posedge clk);
    #1 reinit = 1'b1;
    @(posedge clk);
    #1 reinit = 1'b0;
    @(negedge clk);
    check("t7_ready_pulse", 32'(req_ready), 32'b1000);
    check("t7_init_done_still_high", 32'(init_done), 32'd1);
    @(negedge clk);
    check("t7_init_done_fell", 32'(init_done), 32'd0);
    wait_sent(3, n + 2, 200);
    check("t7_event_count", 32'(ev_kind.size() - m), 32'd8);
    check("t7_first_write", ev_data[m], {24'h0, byte_of(3, n)});
    check_init("t7_reinit", m + 1);
    check("t7_poll_after_init", 32'(ev_kind[m+6]), 32'd1);
    check("t7_second_write", ev_data[m+7], {24'h0, byte_of(3, n + 1)});
    check("t7_init_done_back", 32'(init_done), 32'd1);

    // Asynchronous reset in the middle of a transfer.
    @(posedge clk);
    #1 reinit = 1'b1;
    @(posedge clk);
    #1 reinit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (psel) break;
    end
    check("t8_transfer_active", 32'(psel), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("t8_psel", 32'(psel), 32'd0);
    check("t8_penable", 32'(penable), 32'd0);
    check("t8_paddr", 32'(paddr), 32'd0);
    check("t8_pwdata", pwdata, 32'd0);
    check("t8_init_done", 32'(init_done), 32'd0);

    check("one_hot_ready", 32'(multi_hot), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
